pwd_checker: RTL and testbench

PWD_CHECKER -- requirements
Module: pwd_checker

---
 rtl/lock_pkg.sv | 20 ++
 rtl/digit_buffer.sv | 31 +++
 rtl/pwd_checker.sv | 145 ++++++++++++++
 tb/tb_pwd_checker.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and sizes for the keypad lock: state encoding and password geometry.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CHECK   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam int unsigned PWD_DIGITS = 6;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned PWD_W      = PWD_DIGITS * DIGIT_W;
  localparam int unsigned CNT_W      = 3;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/digit_buffer.sv
// Six-digit BCD shift buffer with fill count; non-BCD digits and digits offered when full are dropped.
module digit_buffer
  import lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] digit,
  output logic [PWD_W-1:0]   value,
  output logic [CNT_W-1:0]   count
);

  logic accept;

  assign accept = shift && is_bcd(digit) && (count < CNT_W'(PWD_DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (accept) begin
      value <= {value[PWD_W-DIGIT_W-1:0], digit};
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pwd_checker.sv
// Keypad password lock: ENTRY -> CHECK -> OPEN / LOCKOUT with fail counting and timed open/alarm.
// Optional in-OPEN password change is enabled by defining PWD_CHANGE_EN.
module pwd_checker
  import lock_pkg::*;
#(
  parameter logic [23:0]  DEFAULT_PWD    = 24'h123456,
  parameter int unsigned  MAX_FAIL       = 3,
  parameter int unsigned  OPEN_CYCLES    = 10,
  parameter int unsigned  LOCKOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       relock,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] digit_cnt,
  output logic [3:0] fail_cnt,
  output logic       pwd_changed
);

  localparam int unsigned TMAX    = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TIMER_W-1:0] OPEN_LAST = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);

  state_t             state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [3:0]         fail_n;
  logic [PWD_W-1:0]   buffer;
  logic [PWD_W-1:0]   pwd;
  logic               buf_shift, buf_clear;
  logic               match;

  digit_buffer u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (buf_shift),
    .clear (buf_clear),
    .digit (key_digit),
    .value (buffer),
    .count (digit_cnt)
  );

  assign match    = (digit_cnt == CNT_W'(PWD_DIGITS)) && (buffer == pwd);
  assign unlocked = (state == ST_OPEN);
  assign alarm    = (state == ST_LOCKOUT);

`ifdef PWD_CHANGE_EN
  logic [PWD_W-1:0] pwd_n;
  logic             chg_n;
`endif

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    fail_n    = fail_cnt;
    buf_shift = 1'b0;
    buf_clear = 1'b0;
`ifdef PWD_CHANGE_EN
    pwd_n     = pwd;
    chg_n     = 1'b0;
`endif
    case (state)
      ST_ENTRY: begin
        if (key_clear)      buf_clear = 1'b1;
        else if (key_enter) state_n   = ST_CHECK;
        else if (key_valid) buf_shift = 1'b1;
      end
      ST_CHECK: begin
        buf_clear = 1'b1;
        timer_n   = '0;
        if (match) begin
          state_n = ST_OPEN;
          fail_n  = '0;
        end else begin
          fail_n  = fail_cnt + 4'd1;
          state_n = (fail_n == 4'(MAX_FAIL)) ? ST_LOCKOUT : ST_ENTRY;
        end
      end
      ST_OPEN: begin
        // leaving OPEN discards any half-typed new password
        if (relock || timer == OPEN_LAST) begin
          state_n   = ST_ENTRY;
          buf_clear = 1'b1;
        end else begin
          timer_n = timer + TIMER_W'(1);
          if (key_clear) buf_clear = 1'b1;
`ifdef PWD_CHANGE_EN
          else if (key_enter) begin
            if (digit_cnt == CNT_W'(PWD_DIGITS)) begin
              pwd_n     = buffer;
              chg_n     = 1'b1;
              buf_clear = 1'b1;
              timer_n   = '0;
            end
          end
          else if (key_valid) buf_shift = 1'b1;
`endif
        end
      end
      ST_LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          state_n   = ST_ENTRY;
          fail_n    = '0;
          buf_clear = 1'b1;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
      default: state_n = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ENTRY;
      timer    <= '0;
      fail_cnt <= '0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      fail_cnt <= fail_n;
    end
  end

`ifdef PWD_CHANGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwd         <= DEFAULT_PWD;
      pwd_changed <= 1'b0;
    end else begin
      pwd         <= pwd_n;
      pwd_changed <= chg_n;
    end
  end
`else
  assign pwd         = DEFAULT_PWD;
  assign pwd_changed = 1'b0;
`endif

endmodule

// File: tb/tb_pwd_checker.sv
// Directed bench for pwd_checker with a queue-based behavioural model checked every cycle.
module tb_pwd_checker;

  localparam logic [23:0] DEF_PWD   = 24'h123456;
  localparam int          MAX_F     = 3;
  localparam int          OPEN_C    = 10;
  localparam int          LOCK_C    = 15;
  localparam int          M_ENTRY   = 0;
  localparam int          M_CHECK   = 1;
  localparam int          M_OPEN    = 2;
  localparam int          M_LOCK    = 3;

  logic       clk, rst_n;
  logic       key_valid, key_enter, key_clear, relock;
  logic [3:0] key_digit;
  logic       unlocked, alarm, pwd_changed;
  logic [2:0] digit_cnt;
  logic [3:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  // model
  int          mq[$];
  int          m_mode, m_remain, m_fails;
  logic [23:0] m_pw;
  bit          m_chg;

  pwd_checker #(
    .DEFAULT_PWD    (DEF_PWD),
    .MAX_FAIL       (MAX_F),
    .OPEN_CYCLES    (OPEN_C),
    .LOCKOUT_CYCLES (LOCK_C)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .relock      (relock),
    .unlocked    (unlocked),
    .alarm       (alarm),
    .digit_cnt   (digit_cnt),
    .fail_cnt    (fail_cnt),
    .pwd_changed (pwd_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] q_value();
    logic [23:0] v = '0;
    foreach (mq[i]) begin
      int t = mq[i];
      v = {v[19:0], t[3:0]};
    end
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode = M_ENTRY; m_remain = 0; m_fails = 0; m_pw = DEF_PWD; m_chg = 0;
  endtask

  task automatic model_step();
    m_chg = 0;
    case (m_mode)
      M_ENTRY: begin
        if (key_clear) mq.delete();
        else if (key_enter) m_mode = M_CHECK;
        else if (key_valid && key_digit <= 9 && mq.size() < 6) mq.push_back(int'(key_digit));
      end
      M_CHECK: begin
        if (mq.size() == 6 && q_value() == m_pw) begin
          m_mode = M_OPEN; m_remain = OPEN_C; m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails == MAX_F) begin m_mode = M_LOCK; m_remain = LOCK_C; end
          else m_mode = M_ENTRY;
        end
        mq.delete();
      end
      M_OPEN: begin
        if (relock || m_remain == 1) begin
          m_mode = M_ENTRY; mq.delete();
        end else begin
          m_remain--;
`ifdef PWD_CHANGE_EN
          if (key_clear) mq.delete();
          else if (key_enter) begin
            if (mq.size() == 6) begin
              m_pw = q_value(); m_chg = 1; mq.delete(); m_remain = OPEN_C;
            end
          end else if (key_valid && key_digit <= 9 && mq.size() < 6) mq.push_back(int'(key_digit));
`else
          if (key_clear) mq.delete();
`endif
        end
      end
      default: begin
        if (m_remain == 1) begin m_mode = M_ENTRY; m_fails = 0; mq.delete(); end
        else m_remain--;
      end
    endcase
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("unlocked",    int'(unlocked),    int'(m_mode == M_OPEN));
      chk("alarm",       int'(alarm),       int'(m_mode == M_LOCK));
      chk("digit_cnt",   int'(digit_cnt),   mq.size());
      chk("fail_cnt",    int'(fail_cnt),    m_fails);
      chk("pwd_changed", int'(pwd_changed), int'(m_chg));
    end
  endtask

  task automatic drive(input bit v, input logic [3:0] d, input bit e, input bit c, input bit r);
    key_valid = v; key_digit = d; key_enter = e; key_clear = c; relock = r;
    @(posedge clk); #1;
    key_valid = 0; key_digit = '0; key_enter = 0; key_clear = 0; relock = 0;
  endtask

  task automatic key(input logic [3:0] d);   drive(1, d, 0, 0, 0); endtask
  task automatic enter();                     drive(0, 4'd0, 1, 0, 0); endtask
  task automatic do_relock();                 drive(0, 4'd0, 0, 0, 1); endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic type_pwd(input logic [23:0] p);
    for (int i = 0; i < 6; i++) key(p[23-4*i -: 4]);
  endtask
  task automatic do_reset();
    @(posedge clk); #2 rst_n = 0;
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic async_reset(input string name);
    #3 rst_n = 0;
    #1 chk({name, "_unlocked"}, int'(unlocked), 0);
    chk({name, "_alarm"}, int'(alarm), 0);
    chk({name, "_fail"}, int'(fail_cnt), 0);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, hi, rises;
    bit prev;
    rst_n = 1; key_valid = 0; key_digit = '0; key_enter = 0; key_clear = 0; relock = 0;
    model_reset();
    fork
      model_loop();
      compare_loop();
    join_none
    #1 rst_n = 0;
    #1;
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_digits", int'(digit_cnt), 0);
    chk("rst_fail", int'(fail_cnt), 0);
    chk("rst_pwdchg", int'(pwd_changed), 0);
    #11 rst_n = 1;
    @(posedge clk); #1;

    // correct password: open two cycles after the enter strobe, for 10 cycles
    type_pwd(24'h123456);
    chk("digits_full", int'(digit_cnt), 6);
    enter();
    chk("open_lat1", int'(unlocked), 0);
    idle(1);
    chk("open_lat2", int'(unlocked), 1);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      idle(1);
      if (unlocked) n++; else break;
    end
    chk("open_len", n, 10);
    chk("open_fail", int'(fail_cnt), 0);

    // five digits only: mismatch
    for (int i = 1; i <= 5; i++) key(4'(i));
    enter();
    idle(1);
    chk("short_fail", int'(fail_cnt), 1);
    chk("short_unlocked", int'(unlocked), 0);
    chk("short_digits", int'(digit_cnt), 0);

    // three wrong attempts -> single alarm of 15 cycles, keys ignored
    do_reset();
    for (int a = 0; a < 3; a++) begin
      type_pwd(24'h654321);
      enter();
      if (a < 2) begin
        idle(1);
        chk("wrong_fail", int'(fail_cnt), a + 1);
      end
    end
    chk("pre_alarm", int'(alarm), 0);
    hi = 0; rises = 0; prev = alarm;
    for (int k = 0; k < 40; k++) begin
      if (k < 6) key(4'(k + 1));
      else if (k == 6) enter();
      else if (k == 7) do_relock();
      else if (k == 8) drive(0, 4'd0, 0, 1, 0);
      else idle(1);
      if (alarm && !prev) rises++;
      if (alarm) hi++;
      prev = alarm;
      if (!alarm && hi > 0) break;
    end
    chk("alarm_rises", rises, 1);
    chk("alarm_len", hi, 15);
    chk("post_alarm_fail", int'(fail_cnt), 0);
    chk("post_alarm_digits", int'(digit_cnt), 0);

    // out-of-range digits ignored; seventh digit ignored
    do_reset();
    key(4'd10);
    key(4'd15);
    type_pwd(24'h123456);
    enter();
    idle(1);
    chk("skip_bcd_open", int'(unlocked), 1);
    key(4'd1);
    do_relock();
    chk("relock_close", int'(unlocked), 0);
    type_pwd(24'h123456);
    key(4'd9);
    chk("seventh_digits", int'(digit_cnt), 6);
    enter();
    idle(1);
    chk("seventh_open", int'(unlocked), 1);
    do_relock();

    // clear beats enter; relock at third OPEN cycle
    type_pwd(24'h123456);
    drive(0, 4'd0, 1, 1, 0);
    chk("clr_enter_digits", int'(digit_cnt), 0);
    idle(1);
    chk("clr_enter_nocheck", int'(unlocked), 0);
    chk("clr_enter_fail", int'(fail_cnt), 0);
    do_relock();
    type_pwd(24'h123456);
    enter();
    idle(1);
    idle(2);
    chk("open_c3", int'(unlocked), 1);
    do_relock();
    chk("relock_c3", int'(unlocked), 0);

    // asynchronous reset mid-OPEN and mid-LOCKOUT
    type_pwd(24'h123456);
    enter();
    idle(3);
    async_reset("rst_open");
    for (int a = 0; a < 3; a++) begin
      type_pwd(24'h000000);
      enter();
    end
    idle(3);
    chk("lock_before_rst", int'(alarm), 1);
    async_reset("rst_lock");

`ifdef PWD_CHANGE_EN
    type_pwd(24'h123456);
    enter();
    idle(1);
    type_pwd(24'h654321);
    enter();
    chk("pwdchg_pulse", int'(pwd_changed), 1);
    idle(1);
    chk("pwdchg_end", int'(pwd_changed), 0);
    do_relock();
    type_pwd(24'h654321);
    enter();
    idle(1);
    chk("newpwd_open", int'(unlocked), 1);
    do_relock();
    do_reset();
    type_pwd(24'h123456);
    enter();
    idle(1);
    chk("defpwd_restored", int'(unlocked), 1);
    do_relock();
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
